// File: rtl/cmp_arbiter_2to1_pkg.sv
// Types and helpers shared by the 2:1 compare-swap arbiter.
package cmp_arbiter_2to1_pkg;

    typedef struct packed {
        logic g0;
        logic g1;
    } grant_t;

    // Round-robin pick: rr names the requester that wins a tie.
    function automatic grant_t rr_grant(
        input logic en,
        input logic v0,
        input logic v1,
        input logic rr
    );
        grant_t g;
        g.g0 = en & v0 & (~v1 | ~rr);
        g.g1 = en & v1 & (~v0 | rr);
        return g;
    endfunction

endpackage

// File: rtl/cmp_swap.sv
// Unsigned compare-swap: lo gets the smaller operand, hi the larger (a wins lo on a tie).
module cmp_swap #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] lo,
    output logic [W-1:0] hi
);

    logic sel;

    assign sel = (a > b);

    mux2_1 #(.W(W)) u_mux_lo (
        .d0  (a),
        .d1  (b),
        .sel (sel),
        .y   (lo)
    );

    mux2_1 #(.W(W)) u_mux_hi (
        .d0  (b),
        .d1  (a),
        .sel (sel),
        .y   (hi)
    );

endmodule

// File: rtl/macro.vh
// Shared constants for the compare/arbiter blocks.
`ifndef MACRO_VH
`define MACRO_VH
`ifndef DATA_LENGTH
`define DATA_LENGTH 8
`endif
`endif

// File: rtl/mux2_1.sv
// Two-input multiplexer: y = sel ? d1 : d0.
module mux2_1 #(
    parameter int W = 8
) (
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic         sel,
    output logic [W-1:0] y
);

    assign y = sel ? d1 : d0;

endmodule

// File: rtl/cmp_arbiter_2to1.sv
// Round-robin 2:1 arbiter feeding a compare-swap into a one-deep result register.
// Handshake: a transfer happens on reqN when reqN_valid & reqN_ready, and on the
// output when out_valid & out_ready; valids never depend on readies.
`include "macro.vh"

module cmp_arbiter_2to1
    import cmp_arbiter_2to1_pkg::*;
#(
    parameter int DATA_LENGTH = `DATA_LENGTH,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req0_valid,
    input  logic [DATA_LENGTH-1:0] req0_a,
    input  logic [DATA_LENGTH-1:0] req0_b,
    output logic                   req0_ready,
    input  logic                   req1_valid,
    input  logic [DATA_LENGTH-1:0] req1_a,
    input  logic [DATA_LENGTH-1:0] req1_b,
    output logic                   req1_ready,
    output logic                   out_valid,
    output logic [DATA_LENGTH-1:0] out_min,
    output logic [DATA_LENGTH-1:0] out_max,
    output logic                   out_src,
    input  logic                   out_ready,
    output logic [CNT_W-1:0]       cnt0,
    output logic [CNT_W-1:0]       cnt1
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic                   ld;
    logic                   rr;
    grant_t                 gnt;
    logic [DATA_LENGTH-1:0] sel_a;
    logic [DATA_LENGTH-1:0] sel_b;
    logic [DATA_LENGTH-1:0] sw_lo;
    logic [DATA_LENGTH-1:0] sw_hi;

    // rst_n gates the load so no ready escapes while reset is held.
    assign ld  = rst_n & (~out_valid | out_ready);
    assign gnt = rr_grant(ld, req0_valid, req1_valid, rr);

    assign req0_ready = gnt.g0;
    assign req1_ready = gnt.g1;

    assign sel_a = gnt.g1 ? req1_a : req0_a;
    assign sel_b = gnt.g1 ? req1_b : req0_b;

    cmp_swap #(.W(DATA_LENGTH)) u_cmp_swap (
        .a  (sel_a),
        .b  (sel_b),
        .lo (sw_lo),
        .hi (sw_hi)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr <= 1'b0;
        end else if (gnt.g0) begin
            rr <= 1'b1;
        end else if (gnt.g1) begin
            rr <= 1'b0;
        end
    end

    // Data fields only move on a grant so they keep their last value when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_min   <= '0;
            out_max   <= '0;
            out_src   <= 1'b0;
        end else if (gnt.g0 | gnt.g1) begin
            out_valid <= 1'b1;
            out_min   <= sw_lo;
            out_max   <= sw_hi;
            out_src   <= gnt.g1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (gnt.g0) begin
                cnt0 <= cnt0 + CNT_ONE;
            end
            if (gnt.g1) begin
                cnt1 <= cnt1 + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_cmp_arbiter_2to1.sv
// Directed and random checks of cmp_arbiter_2to1 against a transaction-level model.
module tb_cmp_arbiter_2to1;

  localparam int DW    = 8;
  localparam int CW    = 4;
  localparam int CMOD  = 1 << CW;

  logic          clk;
  logic          rst_n;
  logic          req0_valid, req1_valid;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic          req0_ready, req1_ready;
  logic          out_valid;
  logic [DW-1:0] out_min, out_max;
  logic          out_src;
  logic          out_ready;
  logic [CW-1:0] cnt0, cnt1;

  int n_checks = 0;
  int n_fail   = 0;

  // scoreboard: pending result {src, max, min}
  logic [2*DW:0] exp_q[$];
  logic [2*DW:0] last_res;
  int            pref;
  int            grants[2];

  cmp_arbiter_2to1 #(.DATA_LENGTH(DW), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_min    (out_min),
    .out_max    (out_max),
    .out_src    (out_src),
    .out_ready  (out_ready),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    last_res  = '0;
    pref      = 0;
    grants[0] = 0;
    grants[1] = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".out_valid"}, out_valid, exp_q.size() > 0);
    chk({tag, ".out_min"}, out_min, last_res[DW-1:0]);
    chk({tag, ".out_max"}, out_max, last_res[2*DW-1:DW]);
    chk({tag, ".out_src"}, out_src, last_res[2*DW]);
    chk({tag, ".cnt0"}, cnt0, grants[0]);
    chk({tag, ".cnt1"}, cnt1, grants[1]);
  endtask

  // driver: one clock cycle of stimulus, called at posedge+1
  task automatic cycle(input string tag,
                       input logic v0, input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                       input logic v1, input logic [DW-1:0] a1, input logic [DW-1:0] b1,
                       input logic ordy);
    int            win;
    logic [DW-1:0] wa, wb, lo, hi;
    bit            can_take;
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
    out_ready  = ordy;
    #1;
    can_take = (exp_q.size() == 0) || ordy;
    win = -1;
    if (can_take) begin
      if (v0 && v1) win = pref;
      else if (v0)  win = 0;
      else if (v1)  win = 1;
    end
    chk({tag, ".req0_ready"}, req0_ready, win == 0);
    chk({tag, ".req1_ready"}, req1_ready, win == 1);
    if (exp_q.size() > 0 && ordy) void'(exp_q.pop_front());
    if (win >= 0) begin
      wa = (win == 1) ? a1 : a0;
      wb = (win == 1) ? b1 : b0;
      lo = (wb < wa) ? wb : wa;
      hi = (wb < wa) ? wa : wb;
      last_res = {win[0], hi, lo};
      exp_q.push_back(last_res);
      grants[win] = (grants[win] + 1) % CMOD;
      pref = 1 - win;
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  // reset asserted between edges while valids are high
  task automatic async_reset(input string tag);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk({tag, ".req0_ready"}, req0_ready, 1'b0);
    chk({tag, ".req1_ready"}, req1_ready, 1'b0);
    check_outputs(tag);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic          v0, v1, ordy;
    logic [DW-1:0] a0, b0, a1, b1;

    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    out_ready = 1'b0;
    model_reset();
    #12;
    chk("rst_hold.req0_ready", req0_ready, 1'b0);
    chk("rst_hold.req1_ready", req1_ready, 1'b0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset.req0_ready", req0_ready, 1'b0);
    chk("reset.req1_ready", req1_ready, 1'b0);
    check_outputs("reset");

    cycle("single", 1'b1, 8'd9, 8'd3, 1'b0, 8'd0, 8'd0, 1'b1);
    cycle("drain", 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0, 1'b1);

    async_reset("reset2");
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      cycle("contend", 1'b1, 8'd5, 8'd7, 1'b1, 8'd8, 8'd2, 1'b1);
    chk("contend.cnt0", cnt0, 4'd2);
    chk("contend.cnt1", cnt1, 4'd2);

    cycle("bp_load", 1'b1, 8'd40, 8'd30, 1'b1, 8'd10, 8'd20, 1'b0);
    for (int i = 0; i < 3; i++)
      cycle("bp_hold", 1'b1, 8'd41, 8'd31, 1'b1, 8'd11, 8'd21, 1'b0);
    cycle("bp_release", 1'b1, 8'd50, 8'd60, 1'b1, 8'd70, 8'd65, 1'b1);

    cycle("equal", 1'b1, 8'hA, 8'hA, 1'b0, 8'd0, 8'd0, 1'b1);
    for (int i = 0; i < CMOD; i++)
      cycle("wrap", 1'b0, 8'd0, 8'd0, 1'b1, 8'(i), 8'(255 - i), 1'b1);
    cycle("idle", 1'b0, 8'd1, 8'd2, 1'b0, 8'd3, 8'd4, 1'b0);
    cycle("drain2", 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0, 1'b1);

    for (int i = 0; i < 300; i++) begin
      v0   = 1'($urandom_range(0, 1));
      v1   = 1'($urandom_range(0, 1));
      ordy = ($urandom_range(0, 3) != 0);
      a0   = 8'($urandom_range(0, 255));
      b0   = ($urandom_range(0, 7) == 0) ? a0 : 8'($urandom_range(0, 255));
      a1   = 8'($urandom_range(0, 255));
      b1   = 8'($urandom_range(0, 255));
      cycle("random", v0, a0, b0, v1, a1, b1, ordy);
    end

    cycle("pre_rst", 1'b1, 8'd200, 8'd100, 1'b0, 8'd0, 8'd0, 1'b0);
    async_reset("midreset");
    @(posedge clk);
    #1;
    cycle("post_rst", 1'b1, 8'd1, 8'd2, 1'b1, 8'd4, 8'd3, 1'b1);
    cycle("post_rst2", 1'b1, 8'd1, 8'd2, 1'b1, 8'd4, 8'd3, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
